// File: rtl/ring_seq_monitor.sv
// Sequence checker for a one-hot ring counter: tracks lock, phase, faults and
// completed rotations, with every output driven from a register.
module ring_seq_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           q,
  input  logic                       clr,
  output logic [1:0]                 state,
  output logic                       locked,
  output logic                       onehot_ok,
  output logic [$clog2(WIDTH)-1:0]   phase,
  output logic                       seq_err,
  output logic [CNT_W-1:0]           err_count,
  output logic [CNT_W-1:0]           rot_count
);

  localparam int PH_W  = $clog2(WIDTH);
  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] WRAP_VAL  = WIDTH'(1);
  localparam logic [RUN_W-1:0] LAST_GOOD = RUN_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'b00,
    ST_TRACK  = 2'b01,
    ST_LOCKED = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  function automatic logic [PH_W-1:0] onehot_idx(input logic [WIDTH-1:0] v);
    logic [PH_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = PH_W'(i);
    end
    return idx;
  endfunction

  state_t              state_q,     state_d;
  logic [WIDTH-1:0]    q_prev_q,    q_prev_d;
  logic [RUN_W-1:0]    good_run_q,  good_run_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [CNT_W-1:0]    rot_count_q, rot_count_d;
  logic [PH_W-1:0]     phase_q,     phase_d;
  logic                seq_err_q,   seq_err_d;
  logic                locked_q,    locked_d;
  logic                onehot_ok_q;

  logic                q_oh_s;
  logic                good_s;
  logic                err_s;
  logic                lock_err_s;

  assign q_oh_s = is_onehot(q);
  assign good_s = (q == {q_prev_q[WIDTH-2:0], q_prev_q[WIDTH-1]});

  always_comb begin
    state_d     = state_q;
    q_prev_d    = q_prev_q;
    good_run_d  = good_run_q;
    err_count_d = err_count_q;
    rot_count_d = rot_count_q;
    phase_d     = phase_q;
    seq_err_d   = seq_err_q;
    err_s       = 1'b0;
    lock_err_s  = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (q_oh_s) begin
          good_run_d = '0;
          state_d    = ST_TRACK;
        end else begin
          state_d    = ST_SYNC;
        end
      end
      ST_TRACK: begin
        if (good_s) begin
          good_run_d = good_run_q + RUN_W'(1);
          if (good_run_q == LAST_GOOD) state_d = ST_LOCKED;
          else                         state_d = ST_TRACK;
        end else begin
          err_s      = 1'b1;
          good_run_d = '0;
          if (q_oh_s) state_d = ST_TRACK;
          else        state_d = ST_SYNC;
        end
      end
      ST_LOCKED: begin
        if (good_s) begin
          if (q == WRAP_VAL) rot_count_d = rot_count_q + CNT_W'(1);
          else               rot_count_d = rot_count_q;
        end else begin
          err_s      = 1'b1;
          lock_err_s = 1'b1;
          state_d    = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (q_oh_s) begin
          good_run_d = '0;
          state_d    = ST_TRACK;
        end else begin
          state_d    = ST_FAULT;
        end
      end
      default: begin
        state_d    = ST_SYNC;
        good_run_d = '0;
      end
    endcase

    // The previous sample and phase only ever hold legal one-hot values.
    if (q_oh_s) begin
      q_prev_d = q;
      phase_d  = onehot_idx(q);
    end else begin
      q_prev_d = q_prev_q;
      phase_d  = phase_q;
    end

    // An error coincident with clr survives as a fresh count of one.
    if (clr) begin
      err_count_d = err_s ? CNT_W'(1) : '0;
      seq_err_d   = lock_err_s;
    end else begin
      if (err_s && (err_count_q != {CNT_W{1'b1}})) err_count_d = err_count_q + CNT_W'(1);
      else                                          err_count_d = err_count_q;
      seq_err_d = seq_err_q | lock_err_s;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      q_prev_q    <= '0;
      good_run_q  <= '0;
      err_count_q <= '0;
      rot_count_q <= '0;
      phase_q     <= '0;
      seq_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      onehot_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_prev_q    <= q_prev_d;
      good_run_q  <= good_run_d;
      err_count_q <= err_count_d;
      rot_count_q <= rot_count_d;
      phase_q     <= phase_d;
      seq_err_q   <= seq_err_d;
      locked_q    <= locked_d;
      onehot_ok_q <= q_oh_s;
    end
  end

  assign state     = state_q;
  assign locked    = locked_q;
  assign onehot_ok = onehot_ok_q;
  assign phase     = phase_q;
  assign seq_err   = seq_err_q;
  assign err_count = err_count_q;
  assign rot_count = rot_count_q;

endmodule

// File: tb/tb_ring_seq_monitor.sv
// Directed bench for ring_seq_monitor: a behavioural reference pushes expected
// outputs into a queue as each sample is driven; they are popped after the edge.
module tb_ring_seq_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] q;
  logic       clr;
  logic [1:0] state;
  logic       locked;
  logic       onehot_ok;
  logic [1:0] phase;
  logic       seq_err;
  logic [7:0] err_count;
  logic [7:0] rot_count;

  ring_seq_monitor #(.WIDTH(4), .LOCK_CNT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .q(q), .clr(clr),
    .state(state), .locked(locked), .onehot_ok(onehot_ok), .phase(phase),
    .seq_err(seq_err), .err_count(err_count), .rot_count(rot_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       lk;
    logic       ok;
    logic [1:0] ph;
    logic       se;
    logic [7:0] ec;
    logic [7:0] rc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference state, written from the behavioural description.
  int   m_st = 0, m_run = 0, m_ec = 0, m_rc = 0, m_ph = 0;
  bit   m_se = 0, m_ok = 0;
  logic [3:0] m_prev = 4'b0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model(input logic [3:0] qi, input logic ci, input logic ri);
    bit oh, good, err, lerr;
    exp_t e;
    oh   = ($countones(qi) == 1);
    good = (qi == {m_prev[2:0], m_prev[3]});
    err  = 0;
    lerr = 0;
    if (ri) begin
      m_st = 0; m_run = 0; m_ec = 0; m_rc = 0; m_ph = 0; m_se = 0; m_ok = 0;
      m_prev = 4'b0000;
    end else begin
      if (m_st == 0) begin
        if (oh) begin m_run = 0; m_st = 1; end
      end else if (m_st == 1) begin
        if (good) begin
          if (m_run == 3) m_st = 2;
          m_run++;
        end else begin
          err = 1; m_run = 0;
          if (!oh) m_st = 0;
        end
      end else if (m_st == 2) begin
        if (good) begin
          if (qi == 4'b0001) m_rc = (m_rc + 1) % 256;
        end else begin
          err = 1; lerr = 1; m_st = 3;
        end
      end else begin
        if (oh) begin m_run = 0; m_st = 1; end
      end
      if (ci) begin
        m_ec = err ? 1 : 0;
        m_se = lerr;
      end else begin
        if (err && m_ec < 255) m_ec++;
        m_se = m_se | lerr;
      end
      if (oh) begin
        m_prev = qi;
        for (int i = 0; i < 4; i++) if (qi[i]) m_ph = i;
      end
      m_ok = oh;
    end
    e.st = 2'(m_st); e.lk = (m_st == 2); e.ok = m_ok; e.ph = 2'(m_ph);
    e.se = m_se;     e.ec = 8'(m_ec);    e.rc = 8'(m_rc);
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] qi, input logic ci, input logic ri);
    exp_t e;
    q = qi; clr = ci; reset = ri;
    model(qi, ci, ri);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check("state",     32'(state),     32'(e.st));
      check("locked",    32'(locked),    32'(e.lk));
      check("onehot_ok", 32'(onehot_ok), 32'(e.ok));
      check("phase",     32'(phase),     32'(e.ph));
      check("seq_err",   32'(seq_err),   32'(e.se));
      check("err_count", 32'(err_count), 32'(e.ec));
      check("rot_count", 32'(rot_count), 32'(e.rc));
    end
  endtask

  function automatic logic [3:0] rot(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  initial begin
    logic [3:0] r;
    reset = 1'b1; clr = 1'b0; q = 4'b0000;

    // Reset, then free run: lock after s4, first rotation at s8.
    step(4'b0000, 1'b0, 1'b1);
    check("rst_state", 32'(state), 32'd0);
    check("rst_err",   32'(err_count), 32'd0);
    r = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step(r, 1'b0, 1'b0);
      check("run_phase", 32'(phase), 32'(i % 4));
      if (i == 3) check("unlocked_s3", 32'(locked), 32'd0);
      if (i == 4) check("locked_s4", 32'(locked), 32'd1);
      if (i == 8) check("rot_s8", 32'(rot_count), 32'd1);
      r = rot(r);
    end

    // Stall at 0100 while locked, then resume the ring from there.
    step(4'b0100, 1'b0, 1'b0);
    check("pre_stall_lock", 32'(state), 32'd2);
    step(4'b0100, 1'b0, 1'b0);
    check("stall_state", 32'(state), 32'd3);
    check("stall_seq",   32'(seq_err), 32'd1);
    check("stall_err",   32'(err_count), 32'd1);
    step(4'b0100, 1'b0, 1'b0);
    check("stall_track", 32'(state), 32'd1);
    r = 4'b1000;
    for (int i = 0; i < 4; i++) begin step(r, 1'b0, 1'b0); r = rot(r); end
    check("relock",      32'(state), 32'd2);
    check("relock_seq",  32'(seq_err), 32'd1);

    // Illegal patterns while locked, recapture on 1000.
    step(4'b1000, 1'b1, 1'b0);
    check("clr_err", 32'(err_count), 32'd0);
    step(4'b0110, 1'b0, 1'b0);
    check("ill_state", 32'(state), 32'd3);
    check("ill_ok",    32'(onehot_ok), 32'd0);
    check("ill_phase", 32'(phase), 32'd3);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0);
    check("zero_state", 32'(state), 32'd3);
    check("zero_err",   32'(err_count), 32'd1);
    step(4'b1000, 1'b0, 1'b0);
    check("recap_state", 32'(state), 32'd1);
    r = 4'b0001;
    for (int i = 0; i < 4; i++) begin step(r, 1'b0, 1'b0); r = rot(r); end
    check("recap_lock", 32'(locked), 32'd1);

    // Saturation in TRACK.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 4'b0100 : 4'b0001, 1'b0, 1'b0);
    check("sat_err",   32'(err_count), 32'd255);
    check("sat_seq",   32'(seq_err), 32'd0);
    check("sat_state", 32'(state), 32'd1);

    // clr coincident with a locked mismatch, then reset mid-lock.
    r = 4'b0010;
    for (int i = 0; i < 4; i++) begin step(r, 1'b0, 1'b0); r = rot(r); end
    check("sat_lock", 32'(state), 32'd2);
    step(4'b0001, 1'b1, 1'b0);
    check("clr_hit_err", 32'(err_count), 32'd1);
    check("clr_hit_seq", 32'(seq_err), 32'd1);
    r = 4'b0010;
    for (int i = 0; i < 5; i++) begin step(r, 1'b0, 1'b0); r = rot(r); end
    check("pre_rst_lock", 32'(state), 32'd2);
    step(r, 1'b0, 1'b1);
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_lock",  32'(locked), 32'd0);
    check("mid_rst_ok",    32'(onehot_ok), 32'd0);
    check("mid_rst_phase", 32'(phase), 32'd0);
    check("mid_rst_seq",   32'(seq_err), 32'd0);
    check("mid_rst_err",   32'(err_count), 32'd0);
    check("mid_rst_rot",   32'(rot_count), 32'd0);

    // 256 full rotations after lock wrap rot_count back to zero.
    r = 4'b0001;
    for (int i = 0; i < 5 + 1024; i++) begin step(r, 1'b0, 1'b0); r = rot(r); end
    check("wrap_rot",  32'(rot_count), 32'd0);
    check("wrap_err",  32'(err_count), 32'd0);
    check("wrap_lock", 32'(locked), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ring_seq_monitor.md
# ring_seq_monitor

Downstream checker for the 4-bit one-hot ring counter: samples the counter's `q` every clock and verifies the legal rotation 0001→0010→0100→1000→0001. It acquires lock after a run of good transitions, flags and counts sequence faults, and reports the current phase and completed rotations. It sits beside any logic that consumes `q` as a phase or select signal, and gives that logic a registered health indication.

## Interface

- `WIDTH`, 4: ring width; `q` and the legal pattern set are WIDTH bits.
- `LOCK_CNT`, 4: consecutive good transitions required to enter LOCKED (≥1).
- `CNT_W`, 8: width of `err_count` and `rot_count`.

- `clk`  in  1  rising-edge clock, same clock as the ring counter.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset, shared with the ring counter.
- `q`  in  WIDTH  ring counter output, sampled every rising edge.
- `clr`  in  1  synchronous clear of `seq_err` and `err_count`.
- `state`  out  2  00 SYNC, 01 TRACK, 10 LOCKED, 11 FAULT.
- `locked`  out  1  high exactly when `state` is LOCKED.
- `onehot_ok`  out  1  the last sampled `q` had exactly one bit set.
- `phase`  out  log2(WIDTH)  index of the set bit of the last sampled `q`; holds its previous value when `q` is not one-hot.
- `seq_err`  out  1  sticky flag: a fault was detected while LOCKED.
- `err_count`  out  CNT_W  mismatch count, saturating at all-ones.
- `rot_count`  out  CNT_W  completed rotations while LOCKED, wrapping modulo 2^CNT_W.

## Operation

- Expected next value: `exp = rot(q_prev) = {q_prev[WIDTH-2:0], q_prev[WIDTH-1]}`. A good transition is `q == exp`.
- Internal registers: `q_prev` (WIDTH bits) and `good_run` (sized to reach LOCK_CNT).
- **SYNC**
  - If `q` is one-hot: set `q_prev` to `q`, set `good_run` to 0, go to TRACK.
  - Otherwise stay in SYNC.
  - Errors are never counted in SYNC.
- **TRACK**
  - Good transition: increment `good_run`. If `good_run` was LOCK_CNT-1, go to LOCKED.
  - Mismatch: increment `err_count` and set `good_run` to 0. If `q` is one-hot, recapture it and stay in TRACK; otherwise go to SYNC.
  - `seq_err` is not set in TRACK.
- **LOCKED**
  - Good transition: stay in LOCKED. If `q` is 0…01 (a wrap), increment `rot_count`.
  - Mismatch, including a stall (`q == q_prev`): set `seq_err`, increment `err_count`, go to FAULT.
- **FAULT**
  - No counting.
  - Once `q` is one-hot: capture it, set `good_run` to 0, go to TRACK.
- In every state, `q_prev` takes the value of `q` whenever `q` is one-hot.
- `clr` clears `seq_err` and `err_count`. If an error occurs in the same cycle as `clr`, the result is `err_count`=1, and `seq_err`=1 if that error happened in LOCKED.
- Priority: `reset` > `clr` > normal update.
- `err_count` saturates at 2^CNT_W-1. `rot_count` wraps.

## Timing

- All outputs are registered. The response to the `q` sampled at edge k is visible immediately after edge k; latency is one cycle from the `q` change.
- Reset values:
  - `state`=SYNC, `locked`=0, `onehot_ok`=0, `phase`=0
  - `seq_err`=0, `err_count`=0, `rot_count`=0
  - internal `q_prev`=0, `good_run`=0
- Reset asserted mid-operation returns everything to the reset values at the next edge, whatever the state.
- With the ring counter released from reset together with the monitor:
  - samples s0=0001: capture, go to TRACK.
  - s1 to s4 are good transitions; `locked`=1 after edge s4 (LOCK_CNT=4).
  - first `rot_count` increment at s8.
- An illegal value costs at least one cycle in FAULT. Relock takes a further LOCK_CNT good transitions after recapture.

## Test plan

- Reset for 1 cycle, then the ring runs freely for 10 cycles (10 ns period). Required: `state` goes SYNC→TRACK→LOCKED, `locked`=1 after s4, `rot_count`=1 after s8, `err_count`=0, `phase` follows 0,1,2,3,0…
- While LOCKED, hold `q`=0100 for 2 cycles (stall). Required: `seq_err`=1, `err_count`=1, `state`=FAULT. Then resume the ring from 0100: TRACK on the next edge, LOCKED 4 good transitions later, `seq_err` still 1.
- While LOCKED, drive 0110 and then 0000 for 3 cycles, then 1000. Required: FAULT, `onehot_ok`=0, `phase` holds, `err_count`=1. Recapture on 1000.
- In TRACK, alternate 0001/0100 for 300 cycles. Required: `err_count` stops at 255, `seq_err` stays 0, `state` stays TRACK.
- Pulse `clr` in the same cycle as a LOCKED mismatch. Required: `err_count`=1, `seq_err`=1. Then assert `reset` mid-LOCKED. Required: all outputs at reset values after one edge.
- With CNT_W=8, free-run 256 full rotations after lock. Required: `rot_count` returns to 0, no errors.
